// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for filtered PLL locks, holds reset,
// then releases staged resets in ascending order.
module reset_sequencer #(
  parameter int NUM_LOCKS   = 2,
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 5000,
  parameter int STAGE_GAP   = 16,
  parameter int LOCK_FILTER = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LOCKS-1:0]  locked,
  input  logic                  sw_reset_req,
  input  logic                  clear_lock_lost,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_released,
  output logic                  lock_lost
);

  localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int FW   = $clog2(LOCK_FILTER + 1);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  logic [NUM_LOCKS-1:0]          sync1;
  logic [NUM_LOCKS-1:0]          sync2;
  logic [NUM_LOCKS-1:0][FW-1:0]  filt;
  logic [NUM_LOCKS-1:0]          stable;
  logic                          all_stable;

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic [NUM_STAGES-1:0] stage_n;
  logic                  loss;

  // Two-flop synchronisers for the asynchronous lock inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= locked;
      sync2 <= sync1;
    end
  end

  // Per-lock saturating filter; one low sample clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        if (!sync2[i])
          filt[i] <= '0;
        else if (filt[i] != FW'(LOCK_FILTER))
          filt[i] <= filt[i] + 1'b1;
      end
    end
  end

  // Stable flags per lock and their conjunction
  always_comb begin
    for (int i = 0; i < NUM_LOCKS; i++)
      stable[i] = (filt[i] == FW'(LOCK_FILTER));
    all_stable = &stable;
  end

  // Sequencer next-state; stages clear by shifting zeros in from bit 0
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stage_n = stage_reset;
    loss    = 1'b0;
    case (state)
      ST_ASSERT: begin
        stage_n = '1;
        if (all_stable) begin
          cnt_n   = CW'(HOLD_CYCLES - 1);
          state_n = ST_HOLD;
        end
      end
      ST_HOLD, ST_RELEASE: begin
        if (!all_stable) begin
          loss    = 1'b1;
          state_n = ST_ASSERT;
          stage_n = '1;
          cnt_n   = '0;
        end else if (sw_reset_req) begin
          state_n = ST_ASSERT;
          stage_n = '1;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          stage_n = stage_reset << 1;
          cnt_n   = CW'(STAGE_GAP - 1);
          state_n = (stage_n == '0) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_RUN: begin
        stage_n = '0;
        if (!all_stable) begin
          loss    = 1'b1;
          state_n = ST_ASSERT;
          stage_n = '1;
        end else if (sw_reset_req) begin
          state_n = ST_ASSERT;
          stage_n = '1;
        end
      end
      default: begin
        state_n = ST_ASSERT;
        stage_n = '1;
        cnt_n   = '0;
      end
    endcase
  end

  // Sequencer state, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      stage_reset  <= '1;
      all_released <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      stage_reset  <= stage_n;
      all_released <= (state_n == ST_RUN);
      if (loss)
        lock_lost <= 1'b1;
      else if (clear_lock_lost)
        lock_lost <= 1'b0;
    end
  end

endmodule
